// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, drives a synchronous Imem
// and buffers returned words in a skid FIFO ahead of decode.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_AW    = 8,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_pc_plus4
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   cred_t;

    logic [31:0] fetch_pc;
    logic [31:0] issued_pc;
    logic        inflight;

    logic [31:0] pc_mem    [FIFO_DEPTH];
    logic [31:0] instr_mem [FIFO_DEPTH];
    ptr_t        rd_ptr;
    ptr_t        wr_ptr;
    cnt_t        count;

    logic        has_data;
    logic        pop;
    logic        push;
    cred_t       credit;
    logic        unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    assign has_data  = (count != '0);
    assign out_valid = has_data && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign push      = inflight && !redirect_valid;

    // Occupancy the FIFO will have once the in-flight word lands.
    assign credit  = cred_t'(count) + cred_t'(inflight) - cred_t'(pop);
    assign imem_en = !rst && !redirect_valid
                   && (credit < cred_t'(FIFO_DEPTH));

    assign imem_addr = fetch_pc[IMEM_AW+1:2];

    assign out_pc       = has_data ? pc_mem[rd_ptr] : 32'h0;
    assign out_instr    = has_data ? instr_mem[rd_ptr] : 32'h0;
    assign out_pc_plus4 = has_data ? pc_mem[rd_ptr] + 32'd4 : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            issued_pc <= 32'h0;
            inflight  <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (imem_en) begin
                fetch_pc  <= fetch_pc + 32'd4;
                issued_pc <= fetch_pc;
            end
            inflight <= imem_en;
            if (push)
                wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)
                rd_ptr <= rd_ptr + ptr_t'(1);
            count <= count + cnt_t'(push) - cnt_t'(pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[wr_ptr]    <= issued_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule
